// File: rtl/rx_frame_parser.sv
// GMII receive front end: qualifies preamble/SFD, tags each byte with its frame field,
// checks the Ethernet FCS and frame length, and flags frames to be discarded at end of frame.
module rx_frame_parser #(
   parameter int pDATA_WIDTH        = 8,
   parameter int pMIN_PACKET_LENGHT = 64,
   parameter int pMAX_PACKET_LENGHT = 1536,
   parameter int pLEN_WIDTH         = $clog2(pMAX_PACKET_LENGHT) + 1
) (
   input  logic                   iclk,
   input  logic                   i_rst,
   input  logic                   irx_dv,
   input  logic [pDATA_WIDTH-1:0] irx_d,
   input  logic                   irx_er,
   output logic                   odv,
   output logic [pDATA_WIDTH-1:0] orx_d,
   output logic [2:0]             oframe_state,
   output logic                   orx_er,
   output logic                   ocrc_ok,
   output logic [pLEN_WIDTH-1:0]  olen
);

   localparam logic [2:0] lpIDLE     = 3'd0;
   localparam logic [2:0] lpPREAMBLE = 3'd1;
   localparam logic [2:0] lpSFD      = 3'd2;
   localparam logic [2:0] lpDA       = 3'd3;
   localparam logic [2:0] lpSA       = 3'd4;
   localparam logic [2:0] lpLEN      = 3'd5;
   localparam logic [2:0] lpDATA     = 3'd6;
   localparam logic [2:0] lpEND      = 3'd7;

   localparam logic [31:0] lpPOLY    = 32'hEDB88320;
   localparam logic [31:0] lpRESIDUE = 32'hDEBB20E3;
   localparam logic [pDATA_WIDTH-1:0] lpPRE_BYTE = pDATA_WIDTH'(8'h55);
   localparam logic [pDATA_WIDTH-1:0] lpSFD_BYTE = pDATA_WIDTH'(8'hD5);
   localparam logic [pLEN_WIDTH-1:0]  lpMIN_LEN  = pLEN_WIDTH'(pMIN_PACKET_LENGHT);
   localparam logic [pLEN_WIDTH-1:0]  lpMAX_LEN  = pLEN_WIDTH'(pMAX_PACKET_LENGHT);

   logic [2:0]            state, nst;
   logic [2:0]            cnt, cnt_nxt;
   logic [31:0]           crc, crc_upd;
   logic [pLEN_WIDTH-1:0] len;
   logic                  err, err_nxt;
   logic                  in_frame, bad;

   function automatic logic [31:0] crc8(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c ^ {24'd0, d};
      for (int i = 0; i < 8; i++)
         r = r[0] ? ((r >> 1) ^ lpPOLY) : (r >> 1);
      return r;
   endfunction

   // nst is the field of the byte currently on irx_d; state holds the previous byte's field
   always_comb begin
      nst     = lpIDLE;
      cnt_nxt = cnt;
      case (state)
         lpIDLE:
            if (irx_dv && irx_d == lpPRE_BYTE) nst = lpPREAMBLE;
         lpPREAMBLE:
            if (irx_dv && irx_d == lpPRE_BYTE)      nst = lpPREAMBLE;
            else if (irx_dv && irx_d == lpSFD_BYTE) nst = lpSFD;
         lpSFD:
            if (!irx_dv) nst = lpEND;
            else begin
               nst     = lpDA;
               cnt_nxt = 3'd5;
            end
         lpDA:
            if (!irx_dv) nst = lpEND;
            else if (cnt == 3'd0) begin
               nst     = lpSA;
               cnt_nxt = 3'd5;
            end else begin
               nst     = lpDA;
               cnt_nxt = cnt - 3'd1;
            end
         lpSA:
            if (!irx_dv) nst = lpEND;
            else if (cnt == 3'd0) begin
               nst     = lpLEN;
               cnt_nxt = 3'd1;
            end else begin
               nst     = lpSA;
               cnt_nxt = cnt - 3'd1;
            end
         lpLEN:
            if (!irx_dv) nst = lpEND;
            else if (cnt == 3'd0) nst = lpDATA;
            else begin
               nst     = lpLEN;
               cnt_nxt = cnt - 3'd1;
            end
         lpDATA:
            nst = irx_dv ? lpDATA : lpEND;
         lpEND:
            if (irx_dv && irx_d == lpPRE_BYTE) nst = lpPREAMBLE;
         default:
            nst = lpIDLE;
      endcase
   end

   assign in_frame = (nst >= lpDA) && (nst <= lpDATA);
   assign crc_upd  = crc8(crc, irx_d[7:0]);

   always_comb begin
      err_nxt = err;
      if (nst == lpSFD)  err_nxt = irx_er;
      else if (in_frame) err_nxt = err | irx_er;
   end

   assign bad = err || (crc != lpRESIDUE) || (len < lpMIN_LEN) || (len > lpMAX_LEN);

   always_ff @(posedge iclk) begin
      if (i_rst) begin
         state        <= lpIDLE;
         cnt          <= 3'd0;
         crc          <= 32'hFFFFFFFF;
         len          <= '0;
         err          <= 1'b0;
         odv          <= 1'b0;
         orx_d        <= '0;
         oframe_state <= lpIDLE;
         orx_er       <= 1'b0;
         ocrc_ok      <= 1'b0;
         olen         <= '0;
      end else begin
         state        <= nst;
         cnt          <= cnt_nxt;
         err          <= err_nxt;
         odv          <= irx_dv;
         orx_d        <= irx_d;
         oframe_state <= (irx_dv || nst == lpEND) ? nst : lpIDLE;
         orx_er       <= 1'b0;
         ocrc_ok      <= 1'b0;
         if (nst == lpSFD) begin
            crc <= 32'hFFFFFFFF;
            len <= '0;
         end else if (in_frame) begin
            crc <= crc_upd;
            if (len != '1) len <= len + 1'b1;
         end
         // early abort hint to the memory stage while the frame is still streaming
         if (nst >= lpSFD && nst <= lpDATA) orx_er <= err_nxt;
         if (nst == lpEND) begin
            olen    <= len;
            orx_er  <= bad;
            ocrc_ok <= !bad;
         end
      end
   end

endmodule

// File: tb/tb_rx_frame_parser.sv
// Bench for rx_frame_parser: frame vectors built into a table, applied cycle by cycle,
// expected outputs queued at drive time and compared one cycle later.
module tb_rx_frame_parser;
   localparam int LW = 12;

   logic          iclk = 1'b0;
   logic          i_rst, irx_dv, irx_er;
   logic [7:0]    irx_d;
   logic          odv, orx_er, ocrc_ok;
   logic [7:0]    orx_d;
   logic [2:0]    oframe_state;
   logic [LW-1:0] olen;

   rx_frame_parser dut (
      .iclk(iclk), .i_rst(i_rst), .irx_dv(irx_dv), .irx_d(irx_d), .irx_er(irx_er),
      .odv(odv), .orx_d(orx_d), .oframe_state(oframe_state), .orx_er(orx_er),
      .ocrc_ok(ocrc_ok), .olen(olen)
   );

   always #5 iclk = ~iclk;

   typedef struct {
      logic          rst, dv, er;
      logic [7:0]    d;
      logic [2:0]    st;
      logic          x_er, x_ok, chk_len;
      logic [LW-1:0] len;
   } vec_t;

   vec_t vecs[$];
   vec_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      logic        fb;
      r = c;
      for (int i = 0; i < 8; i++) begin
         fb = r[0] ^ d[i];
         r  = {1'b0, r[31:1]} ^ (fb ? 32'hEDB88320 : 32'h0);
      end
      return r;
   endfunction

   task automatic add(input int rst, input int dv, input int er, input int d, input int st,
                      input int x_er, input int x_ok, input int chk_len, input int len);
      vec_t v;
      v.rst = 1'(rst); v.dv = 1'(dv); v.er = 1'(er); v.d = 8'(d); v.st = 3'(st);
      v.x_er = 1'(x_er); v.x_ok = 1'(x_ok); v.chk_len = 1'(chk_len); v.len = LW'(len);
      vecs.push_back(v);
   endtask

   function automatic int field_of(input int i);
      if (i < 6)  return 3;
      if (i < 12) return 4;
      if (i < 14) return 5;
      return 6;
   endfunction

   // body bytes = seed ^ (i*step), FCS appended LSB first; flip/er_at < 0 disables them
   task automatic add_frame(input int npre, input int nbody, input int seed, input int step,
                            input int flip, input int er_at, input int bad, input int b2b);
      logic [7:0]  body[$];
      logic [31:0] c;
      c = 32'hFFFFFFFF;
      for (int i = 0; i < nbody; i++) begin
         body.push_back(8'(seed) ^ 8'(i * step));
         c = crc_byte(c, body[i]);
      end
      c = ~c;
      for (int i = 0; i < 4; i++) body.push_back(c[8*i +: 8]);
      if (flip >= 0) body[flip] = body[flip] ^ 8'h01;
      for (int i = 0; i < npre; i++) add(0, 1, 0, 8'h55, 1, 0, 0, 0, 0);
      add(0, 1, 0, 8'hD5, 2, 0, 0, 0, 0);
      for (int i = 0; i < body.size(); i++)
         add(0, 1, int'(i == er_at), int'(body[i]), field_of(i),
             int'(er_at >= 0 && i >= er_at), 0, 0, 0);
      add(0, 0, 0, 0, 7, bad, int'(bad == 0), 1, body.size());
      if (b2b == 0) add(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic check_vec(input vec_t v);
      chk("odv",          32'(odv),          32'(v.rst ? 1'b0 : v.dv));
      chk("orx_d",        32'(orx_d),        32'(v.rst ? 8'h00 : v.d));
      chk("oframe_state", 32'(oframe_state), 32'(v.st));
      chk("orx_er",       32'(orx_er),       32'(v.x_er));
      chk("ocrc_ok",      32'(ocrc_ok),      32'(v.x_ok));
      if (v.chk_len) chk("olen", 32'(olen), 32'(v.len));
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int ok_pulses;
      i_rst = 1'b1; irx_dv = 1'b0; irx_d = 8'h00; irx_er = 1'b0;
      repeat (3) @(negedge iclk);
      chk("rst_odv",     32'(odv),          0);
      chk("rst_orx_d",   32'(orx_d),        0);
      chk("rst_state",   32'(oframe_state), 0);
      chk("rst_orx_er",  32'(orx_er),       0);
      chk("rst_ocrc_ok", 32'(ocrc_ok),      0);
      chk("rst_olen",    32'(olen),         0);
      i_rst = 1'b0;

      add(0, 0, 0, 0, 0, 0, 0, 0, 0);
      // good 64-byte frame, all-zero body
      add_frame(7, 60, 8'h00, 0, -1, -1, 0, 0);
      // one payload bit flipped
      add_frame(7, 60, 8'h00, 0, 20, -1, 1, 0);
      // PHY error on DA byte 3
      add_frame(7, 60, 8'hA5, 3, -1, 2, 1, 0);
      // broken preamble, then a back-to-back pair of good frames
      add(0, 1, 0, 8'h55, 1, 0, 0, 0, 0);
      add(0, 1, 0, 8'h55, 1, 0, 0, 0, 0);
      add(0, 1, 0, 8'h12, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0);
      add_frame(3, 80, 8'h3C, 5, -1, -1, 0, 1);
      add_frame(7, 60, 8'h11, 1, -1, -1, 0, 0);
      // runt with good FCS, then oversize frame
      add_frame(7, 36, 8'h42, 7, -1, -1, 1, 0);
      add_frame(7, 1596, 8'h9E, 13, -1, -1, 1, 0);
      // reset in the middle of DATA, then a good frame
      for (int i = 0; i < 7; i++) add(0, 1, 0, 8'h55, 1, 0, 0, 0, 0);
      add(0, 1, 0, 8'hD5, 2, 0, 0, 0, 0);
      for (int i = 0; i < 20; i++) add(0, 1, 0, i + 1, field_of(i), 0, 0, 0, 0);
      add(1, 1, 0, 8'h77, 0, 0, 0, 1, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0);
      add_frame(7, 60, 8'h5A, 9, -1, -1, 0, 0);

      for (int k = 0; k <= vecs.size(); k++) begin
         @(negedge iclk);
         if (sb.size() > 0) check_vec(sb.pop_front());
         if (k < vecs.size()) begin
            i_rst  = vecs[k].rst;
            irx_dv = vecs[k].dv;
            irx_d  = vecs[k].d;
            irx_er = vecs[k].er;
            sb.push_back(vecs[k]);
         end
      end
      i_rst = 1'b0; irx_dv = 1'b0; irx_d = 8'h00; irx_er = 1'b0;

      // streamed good frame: ocrc_ok must pulse exactly once within a bounded window
      vecs.delete();
      add_frame(7, 64, 8'hC3, 3, -1, -1, 0, 0);
      ok_pulses = 0;
      for (int k = 0; k < vecs.size(); k++) begin
         @(negedge iclk);
         if (ocrc_ok) ok_pulses++;
         irx_dv = vecs[k].dv;
         irx_d  = vecs[k].d;
         irx_er = vecs[k].er;
      end
      irx_dv = 1'b0; irx_d = 8'h00;
      repeat (8) begin
         @(negedge iclk);
         if (ocrc_ok) ok_pulses++;
      end
      chk("ok_pulse_count", 32'(ok_pulses), 1);
      chk("olen_stream",    32'(olen),      68);
      chk("idle_after",     32'(oframe_state), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
